pipe_alu: RTL and testbench
===========================

PIPE_ALU -- requirements
Module: pipe_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning operand/result width in bits; WIDTH SHALL be even and >= 4.
REQ-002 The block SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 The block SHALL have port start, input, 1, request to begin an operation on the current operands.
REQ-005 The block SHALL have ports inA and inB, input, WIDTH, signed operands.
REQ-006 The block SHALL have port inC, input, 1, carry-in, used by opc 010 only.
REQ-007 The block SHALL have port opc, input, 3, operation select.
REQ-008 The block SHALL have port outW, output, WIDTH, registered result.
REQ-009 The block SHALL have ports zer, neg, ovf, output, 1 each, registered flags: result zero, result MSB, signed overflow.
REQ-010 The block SHALL have ports busy and done, output, 1 each: multi-cycle op in progress; one-cycle completion pulse.

Function
REQ-011 The block SHALL have states IDLE and MUL; start is accepted only in IDLE; start while busy=1 SHALL be ignored with no effect.
REQ-012 On accepted start, opc 000..110 SHALL complete at that same edge: outW, flags updated, done=1 for exactly one cycle; state stays IDLE.
REQ-013 Single-cycle ops SHALL be: 000 two's-complement negate of inA; 001 inA+1; 010 inA+inB+inC; 011 (inA+inB) summed at WIDTH+1 bits, arithmetic shift right 1, low WIDTH bits kept; 100 inA&inB; 101 inA|inB; 110 {inA[WIDTH/2-1:0], inB[WIDTH/2-1:0]}.
REQ-014 All sums SHALL wrap modulo 2^WIDTH except opc 011, which never overflows.
REQ-015 zer SHALL equal (outW==0); neg SHALL equal outW[WIDTH-1]; both recomputed on every completion.
REQ-016 ovf SHALL be 1 only for opc 010 when operands share sign and result sign differs; 0 for every other opc.
REQ-017 opc 111 SHALL be an unsigned shift-add multiply, low WIDTH bits of inA*inB: accepted start captures operands, enters MUL, busy=1.
REQ-018 MUL SHALL perform one shift-add iteration per cycle for WIDTH cycles; busy SHALL be high exactly WIDTH cycles; at the edge ending the last iteration outW/flags load, done=1 one cycle, busy=0, state returns IDLE.
REQ-019 Operand, opc, inC changes while busy SHALL not affect the result in progress.
REQ-020 outW and flags SHALL hold their last value between completions; done SHALL be 0 whenever no completion occurs.
REQ-021 A start accepted in the cycle done is high (IDLE) SHALL be honoured; back-to-back single-cycle ops give done high on consecutive cycles.

Reset
REQ-022 rst=1 SHALL force outW=0, zer=0, neg=0, ovf=0, busy=0, done=0, state IDLE at the next edge, overriding start.
REQ-023 rst during MUL SHALL abort the multiply with no done pulse; partial product discarded.

Configuration
REQ-024 Macro PIPE_ALU_MUL_EN SHALL gate the multiplier: defined, opc 111 behaves per REQ-017/018.
REQ-025 Without PIPE_ALU_MUL_EN, opc 111 SHALL complete as a single-cycle op with outW=0, zer=1, neg=0, ovf=0, busy never asserted, and no MUL state or multiplier logic present.

Verification (WIDTH=16, PIPE_ALU_MUL_EN defined unless noted)
REQ-026 Hold rst=1 two cycles with start=1, opc=010 -> outW=0x0000, all flags 0, busy=0, done=0.
REQ-027 start, opc=010, inA=0x7FFF, inB=0x0001, inC=1 -> next cycle outW=0x8001, neg=1, ovf=1, zer=0, done=1 one cycle.
REQ-028 start, opc=011, inA=0x7FFF, inB=0x7FFF -> outW=0x7FFF, ovf=0; then opc=000, inA=0x0000 next cycle -> outW=0x0000, zer=1, done on both cycles.
REQ-029 start, opc=111, inA=0x0012, inB=0x0034; pulse start with opc=100 mid-op -> busy high 16 cycles, single done, outW=0x03A8; AND request ignored.
REQ-030 opc=111 multiply started, rst=1 on 5th busy cycle -> busy=0, outW=0, no done; without PIPE_ALU_MUL_EN opc=111 -> outW=0, zer=1, done next cycle, busy=0.

Source files
------------

// File: rtl/pipe_alu.sv
// Two-state ALU: single-cycle arithmetic/logic ops plus an optional shift-add multiplier.
// Define PIPE_ALU_MUL_EN to build the multiplier; otherwise opc 111 yields zero in one cycle.
module pipe_alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             inC,
  input  logic [2:0]       opc,
  output logic [WIDTH-1:0] outW,
  output logic             zer,
  output logic             neg,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int HW = WIDTH / 2;

  logic [WIDTH-1:0] outw_q, outw_d;
  logic             zer_q, zer_d;
  logic             neg_q, neg_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] add_w;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] alu_w;
  logic             alu_v;
  logic             fin;
  logic [WIDTH-1:0] fin_w;
  logic             fin_v;

  always_comb begin
    add_w   = inA + inB + {{(WIDTH-1){1'b0}}, inC};
    sum_ext = {inA[WIDTH-1], inA} + {inB[WIDTH-1], inB};
    alu_w   = '0;
    alu_v   = 1'b0;
    unique case (opc)
      3'b000: alu_w = '0 - inA;
      3'b001: alu_w = inA + {{(WIDTH-1){1'b0}}, 1'b1};
      3'b010: begin
        alu_w = add_w;
        alu_v = (inA[WIDTH-1] == inB[WIDTH-1]) &&
                (add_w[WIDTH-1] != inA[WIDTH-1]);
      end
      // Sign-extended sum halved: the average can never overflow.
      3'b011: alu_w = WIDTH'(sum_ext >> 1);
      3'b100: alu_w = inA & inB;
      3'b101: alu_w = inA | inB;
      3'b110: alu_w = {inA[HW-1:0], inB[HW-1:0]};
      3'b111: alu_w = '0;
    endcase
  end

`ifdef PIPE_ALU_MUL_EN

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_next;

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
    fin      = 1'b0;
    fin_w    = '0;
    fin_v    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && opc == 3'b111) begin
          mcand_d  = inA;
          mplier_d = inB;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = MUL;
        end else if (start) begin
          fin   = 1'b1;
          fin_w = alu_w;
          fin_v = alu_v;
        end
      end
      MUL: begin
        acc_d    = acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          fin     = 1'b1;
          fin_w   = acc_next;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy = (state_q == MUL);

`else

  always_comb begin
    fin   = start;
    fin_w = alu_w;
    fin_v = alu_v;
  end

  assign busy = 1'b0;

`endif

  always_comb begin
    outw_d = outw_q;
    zer_d  = zer_q;
    neg_d  = neg_q;
    ovf_d  = ovf_q;
    done_d = 1'b0;
    if (fin) begin
      outw_d = fin_w;
      zer_d  = (fin_w == '0);
      neg_d  = fin_w[WIDTH-1];
      ovf_d  = fin_v;
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outw_q <= '0;
      zer_q  <= 1'b0;
      neg_q  <= 1'b0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      outw_q <= outw_d;
      zer_q  <= zer_d;
      neg_q  <= neg_d;
      ovf_q  <= ovf_d;
      done_q <= done_d;
    end
  end

  assign outW = outw_q;
  assign zer  = zer_q;
  assign neg  = neg_q;
  assign ovf  = ovf_q;
  assign done = done_q;

endmodule

// File: tb/tb_pipe_alu.sv
// Self-checking bench for pipe_alu: vector table, corner sequences, random ops
// against an arithmetic reference model.
module tb_pipe_alu;

  localparam int W = 16;
`ifdef PIPE_ALU_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, start, inC;
  logic [W-1:0] inA, inB;
  logic [2:0]   opc;
  logic [W-1:0] outW;
  logic         zer, neg, ovf, busy, done;

  int n_chk  = 0;
  int n_pass = 0;
  logic [W-1:0] last_w;

  always #5 clk = ~clk;

  pipe_alu #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .inA  (inA),
    .inB  (inB),
    .inC  (inC),
    .opc  (opc),
    .outW (outW),
    .zer  (zer),
    .neg  (neg),
    .ovf  (ovf),
    .busy (busy),
    .done (done)
  );

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    logic [W-1:0] w;
    logic         z;
    logic         n;
    logic         v;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic void model(input logic [2:0] op,
                                input logic [W-1:0] a, b,
                                input logic c,
                                output logic [W-1:0] w,
                                output logic v);
    int     sa, sb, s;
    longint p;
    sa = int'($signed(a));
    sb = int'($signed(b));
    v  = 1'b0;
    w  = '0;
    case (op)
      3'd0: w = W'(-sa);
      3'd1: w = W'(sa + 1);
      3'd2: begin
        s = sa + sb + int'(c);
        w = W'(s);
        v = (s > 32767) || (s < -32768);
      end
      3'd3: w = W'((sa + sb) >>> 1);
      3'd4: w = a & b;
      3'd5: w = a | b;
      3'd6: w = {a[7:0], b[7:0]};
      default: begin
        p = longint'(a) * longint'(b);
        w = MUL_ON ? W'(p) : '0;
      end
    endcase
  endfunction

  task automatic run_op(input string nm, input logic [2:0] op,
                        input logic [W-1:0] a, b, input logic c);
    logic [W-1:0] ew;
    logic         ev;
    int           bc, g;
    model(op, a, b, c, ew, ev);
    start = 1'b1; opc = op; inA = a; inB = b; inC = c;
    @(posedge clk); #1;
    start = 1'b0;
    if (MUL_ON && op == 3'b111) begin
      bc = int'(busy);
      g  = 0;
      while (!done && g < 40) begin
        inA   = W'($urandom);
        inB   = W'($urandom);
        inC   = 1'($urandom);
        opc   = 3'($urandom);
        start = ($urandom_range(0, 3) == 0);
        @(posedge clk); #1;
        bc += int'(busy);
        g++;
      end
      start = 1'b0;
      chk({nm, " busy_cycles"}, bc, W);
    end
    chk({nm, " done"}, done, 1);
    chk({nm, " busy"}, busy, 0);
    chk({nm, " outW"}, outW, ew);
    chk({nm, " flags"}, {zer, neg, ovf}, {ew == 0, ew[W-1], ev});
    last_w = ew;
  endtask

  initial begin
    int bc, dc, g;
    logic [2:0] op;
    logic [W-1:0] a, b;
    logic [W-1:0] edges[4];

    tbl[0]  = '{3'b010, 16'h7FFF, 16'h0001, 1'b1, 16'h8001, 1'b0, 1'b1, 1'b1};
    tbl[1]  = '{3'b011, 16'h7FFF, 16'h7FFF, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{3'b000, 16'h0000, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{3'b000, 16'h0001, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{3'b000, 16'h8000, 16'h0000, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{3'b001, 16'hFFFF, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{3'b001, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{3'b010, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{3'b010, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{3'b011, 16'h8000, 16'h8000, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{3'b011, 16'hFFFF, 16'h0000, 1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{3'b100, 16'hF0F0, 16'h3C3C, 1'b0, 16'h3030, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{3'b101, 16'hF000, 16'h000F, 1'b0, 16'hF00F, 1'b0, 1'b1, 1'b0};
    tbl[13] = '{3'b110, 16'h1234, 16'h5678, 1'b0, 16'h3478, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{3'b010, 16'h1234, 16'h0000, 1'b1, 16'h1235, 1'b0, 1'b0, 1'b0};

    edges[0] = 16'h0000; edges[1] = 16'h7FFF;
    edges[2] = 16'h8000; edges[3] = 16'hFFFF;

    rst = 1'b1; start = 1'b1; opc = 3'b010;
    inA = 16'h7FFF; inB = 16'h0001; inC = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("reset outW", outW, 0);
      chk("reset zer/neg/ovf/busy/done", {zer, neg, ovf, busy, done}, 0);
    end
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    chk("idle done", done, 0);

    foreach (tbl[i]) begin
      start = 1'b1; opc = tbl[i].op;
      inA = tbl[i].a; inB = tbl[i].b; inC = tbl[i].c;
      @(posedge clk); #1;
      chk($sformatf("vec%0d done", i), done, 1);
      chk($sformatf("vec%0d outW", i), outW, tbl[i].w);
      chk($sformatf("vec%0d flags", i), {zer, neg, ovf},
          {tbl[i].z, tbl[i].n, tbl[i].v});
    end
    start = 1'b0; inA = 16'hAAAA; inB = 16'h5555;
    @(posedge clk); #1;
    chk("hold done", done, 0);
    chk("hold outW", outW, 16'h1235);

    if (MUL_ON) begin
      start = 1'b1; opc = 3'b111; inA = 16'h0012; inB = 16'h0034; inC = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      bc = int'(busy); dc = int'(done); g = 0;
      while (!done && g < 40) begin
        start = (g == 3); opc = 3'b100; inA = 16'hFFFF; inB = 16'hFFFF;
        @(posedge clk); #1;
        bc += int'(busy); dc += int'(done); g++;
      end
      start = 1'b0;
      chk("mul busy_cycles", bc, 16);
      chk("mul outW", outW, 16'h03A8);
      @(posedge clk); #1;
      dc += int'(done);
      chk("mul done_count", dc, 1);
      chk("mul and_ignored outW", outW, 16'h03A8);

      start = 1'b1; opc = 3'b111; inA = 16'h00FF; inB = 16'h0101;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) begin
        @(posedge clk); #1;
      end
      chk("abort busy_before", busy, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort busy", busy, 0);
      chk("abort outW", outW, 0);
      chk("abort done", done, 0);
      dc = 0;
      repeat (20) begin
        @(posedge clk); #1;
        dc += int'(done);
      end
      chk("abort no_done", dc, 0);
      run_op("mul after abort", 3'b111, 16'h00FF, 16'h0101, 1'b0);
      run_op("mul wrap", 3'b111, 16'hFFFF, 16'hFFFF, 1'b0);
    end else begin
      run_op("mul disabled", 3'b111, 16'h1234, 16'h5678, 1'b1);
    end
    run_op("b2b after mul", 3'b010, 16'h8000, 16'hFFFF, 1'b0);

    for (int i = 0; i < 150; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = W'($urandom);
      b  = W'($urandom);
      if ($urandom_range(0, 3) == 0) a = edges[$urandom_range(0, 3)];
      if ($urandom_range(0, 3) == 0) b = edges[$urandom_range(0, 3)];
      run_op($sformatf("rnd%0d op%0d", i, op), op, a, b, 1'($urandom));
      if ($urandom_range(0, 4) == 0) begin
        inA = W'($urandom); opc = 3'($urandom);
        @(posedge clk); #1;
        chk($sformatf("rnd%0d gap done", i), done, 0);
        chk($sformatf("rnd%0d gap outW", i), outW, last_w);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
